// File: rtl/eq_response_checker.sv
// eq_response_checker: checking end of the equality-comparator test flow.
// Accepts (a, b, dut_eq) vectors, compares dut_eq against a == b, counts
// vectors and mismatches, latches the first failing vector and reports
// pass/fail once NUM_VECTORS vectors have been accepted.
//
// Handshake: a vector transfers on a rising edge where in_valid && in_ready;
// in_ready depends only on state (high in RUN), never on in_valid, and
// in_valid may be low for any number of cycles without penalty.
module eq_response_checker #(
  parameter int WIDTH       = 2,
  parameter int NUM_VECTORS = 16,
  localparam int CNT_W      = $clog2(NUM_VECTORS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             dut_eq,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VECTORS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             fail_valid_q, fail_valid_d;
  logic [WIDTH-1:0] fail_a_q, fail_a_d;
  logic [WIDTH-1:0] fail_b_q, fail_b_d;
  logic             pass_q, pass_d;

  logic accept;
  logic mismatch;

  assign accept   = in_valid && (state_q == RUN);
  assign mismatch = dut_eq != (a == b);

  // Next-state and counter/record updates for the IDLE/RUN/DONE run control.
  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_a_d     = fail_a_q;
    fail_b_d     = fail_b_q;
    pass_d       = pass_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = RUN;
          vec_d        = '0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_a_d     = '0;
          fail_b_d     = '0;
          pass_d       = 1'b0;
        end
      end
      RUN: begin
        if (accept) begin
          vec_d = vec_q + 1'b1;
          if (mismatch) begin
            err_d = err_q + 1'b1;
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              fail_a_d     = a;
              fail_b_d     = b;
            end
          end
          // pass uses err_d so the final vector's result is included.
          if (vec_d == LAST_CNT) begin
            state_d = DONE;
            pass_d  = (err_d == '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset aborts any run back to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_a_q     <= fail_a_d;
      fail_b_q     <= fail_b_d;
      pass_q       <= pass_d;
    end
  end

  assign in_ready   = (state_q == RUN);
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign vec_count  = vec_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_a     = fail_a_q;
  assign fail_b     = fail_b_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_eq_response_checker.sv
// Bench for eq_response_checker: directed runs checked against a
// run-level behavioural model every cycle, plus literal expectations.
module tb_eq_response_checker;

  localparam int WIDTH = 2;
  localparam int NUM   = 16;
  localparam int CNT_W = $clog2(NUM + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             dut_eq = 1'b0;
  logic             in_ready, busy, done, pass, fail_valid;
  logic [CNT_W-1:0] vec_count, err_count;
  logic [WIDTH-1:0] fail_a, fail_b;
  logic [1:0]       state_dbg;

  eq_response_checker #(.WIDTH(WIDTH), .NUM_VECTORS(NUM)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .dut_eq(dut_eq), .busy(busy),
    .done(done), .pass(pass), .vec_count(vec_count), .err_count(err_count),
    .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b),
    .state_dbg(state_dbg)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A run is "active" between start and the NUM-th accepted vector.
  bit m_active = 0, m_finished = 0, m_fv = 0, m_pass = 0;
  int m_vec = 0, m_err = 0, m_fa = 0, m_fb = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active = 0; m_finished = 0; m_fv = 0; m_pass = 0;
      m_vec = 0; m_err = 0; m_fa = 0; m_fb = 0;
    end else if (m_active) begin
      if (in_valid) begin
        m_vec++;
        if (dut_eq != (a == b)) begin
          m_err++;
          if (!m_fv) begin m_fv = 1; m_fa = int'(a); m_fb = int'(b); end
        end
        if (m_vec == NUM) begin
          m_active = 0; m_finished = 1; m_pass = (m_err == 0);
        end
      end
    end else if (start) begin
      m_active = 1; m_finished = 0; m_fv = 0; m_pass = 0;
      m_vec = 0; m_err = 0; m_fa = 0; m_fb = 0;
    end
  end

  // ---------------- scoreboard compare, every falling edge ----------------
  always @(negedge clk) begin
    chk("in_ready",   int'(in_ready),   int'(m_active));
    chk("busy",       int'(busy),       int'(m_active));
    chk("done",       int'(done),       int'(m_finished));
    chk("pass",       int'(pass),       int'(m_pass));
    chk("vec_count",  int'(vec_count),  m_vec);
    chk("err_count",  int'(err_count),  m_err);
    chk("fail_valid", int'(fail_valid), int'(m_fv));
    chk("fail_a",     int'(fail_a),     m_fa);
    chk("fail_b",     int'(fail_b),     m_fb);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Vector i of the exhaustive sweep: a = i[3:2], b = i[1:0].
  task automatic send_vec(input int i, input bit invert, input bit gap);
    logic [3:0] iv;
    iv = 4'(i);
    a = iv[3:2];
    b = iv[1:0];
    dut_eq = (iv[3:2] == iv[1:0]) ^ invert;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (gap) tick();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    repeat (2) tick();
    chk("reset_vec", int'(vec_count), 0);
    chk("reset_ready", int'(in_ready), 0);
    reset_n = 1'b1;
    tick();

    // Test 6: vector with mismatch in IDLE is ignored.
    a = 2'b01; b = 2'b10; dut_eq = 1'b1; in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("t6_ready", int'(in_ready), 0);
    chk("t6_vec", int'(vec_count), 0);
    chk("t6_err", int'(err_count), 0);

    // Test 1: correct DUT, back-to-back vectors; done on cycle 17.
    pulse_start();
    chk("t1_ready_c1", int'(in_ready), 1);
    for (int i = 0; i < NUM; i++) begin
      chk("t1_not_done", int'(done), 0);
      send_vec(i, 1'b0, 1'b0);
    end
    chk("t1_done", int'(done), 1);
    chk("t1_pass", int'(pass), 1);
    chk("t1_vec", int'(vec_count), 16);
    chk("t1_err", int'(err_count), 0);
    chk("t1_fv", int'(fail_valid), 0);

    // Test 2: inverted at (01,01) = vector 5 and (11,10) = vector 14.
    pulse_start();
    for (int i = 0; i < NUM; i++) send_vec(i, (i == 5) || (i == 14), 1'b0);
    chk("t2_err", int'(err_count), 2);
    chk("t2_fa", int'(fail_a), 1);
    chk("t2_fb", int'(fail_b), 1);
    chk("t2_fv", int'(fail_valid), 1);
    chk("t2_pass", int'(pass), 0);
    chk("t2_done", int'(done), 1);

    // Test 3: in_valid toggled; count advances only on valid cycles.
    pulse_start();
    for (int i = 0; i < NUM; i++) begin
      send_vec(i, 1'b0, 1'b1);
      chk("t3_vec", int'(vec_count), i + 1);
      if (i < NUM - 1) chk("t3_busy", int'(busy), 1);
    end
    chk("t3_done", int'(done), 1);
    chk("t3_pass", int'(pass), 1);

    // Test 4: reset after 7 accepts, then a fresh full run.
    pulse_start();
    for (int i = 0; i < 7; i++) send_vec(i, i == 3, 1'b0);
    chk("t4_vec7", int'(vec_count), 7);
    #2 reset_n = 1'b0;
    #1;
    chk("t4_rst_vec", int'(vec_count), 0);
    chk("t4_rst_err", int'(err_count), 0);
    chk("t4_rst_busy", int'(busy), 0);
    chk("t4_rst_fv", int'(fail_valid), 0);
    tick();
    reset_n = 1'b1;
    tick();
    pulse_start();
    for (int i = 0; i < NUM; i++) send_vec(i, 1'b0, 1'b0);
    chk("t4_vec", int'(vec_count), 16);
    chk("t4_pass", int'(pass), 1);

    // Test 5: start in RUN is ignored; start in DONE clears.
    pulse_start();
    for (int i = 0; i < 5; i++) send_vec(i, 1'b0, 1'b0);
    pulse_start();
    chk("t5_noclr", int'(vec_count), 5);
    for (int i = 5; i < NUM; i++) begin
      send_vec(i, 1'b0, 1'b0);
      chk("t5_vec", int'(vec_count), i + 1);
    end
    chk("t5_done", int'(done), 1);
    pulse_start();
    chk("t5_clr_vec", int'(vec_count), 0);
    chk("t5_busy", int'(busy), 1);
    chk("t5_done_lo", int'(done), 0);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
